instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, instruction register and single-outstanding fetch FSM
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        PCIncrement,
  input  logic        PCReset,
  input  logic [15:0] PCIn,
  input  logic        IRWrite,
  input  logic        IRReset,
  input  logic [15:0] MemData,
  input  logic        MemAck,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  output logic [15:0] PC,
  output logic [15:0] INS,
  output logic        FetchValid,
  output logic        FetchErr,
  output logic        Busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Last wait-count value before a fetch is abandoned; the REQ state lasts TIMEOUT cycles.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_mem_addr;
  logic        r_mem_req;
  logic [7:0]  r_cnt;
  logic        r_fetch_valid;
  logic        r_fetch_err;

  // Program counter: PCReset beats PCWrite beats PCIncrement; free to change during a fetch.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_pc <= RESET_PC;
    end else if (PCReset) begin
      r_pc <= RESET_PC;
    end else if (PCWrite) begin
      r_pc <= PCIn;
    end else if (PCIncrement) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  // Fetch FSM: latch the address on entry to REQ, then wait for MemAck or the timeout.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_ir          <= 16'h0000;
      r_mem_addr    <= 16'h0000;
      r_mem_req     <= 1'b0;
      r_cnt         <= 8'd0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      if (IRReset) begin
        r_ir      <= 16'h0000;
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
        r_cnt     <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (IRWrite) begin
              r_state    <= S_REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_pc;
              r_cnt      <= 8'd0;
            end
          end
          S_REQ: begin
            if (MemAck) begin
              r_ir          <= MemData;
              r_state       <= S_IDLE;
              r_mem_req     <= 1'b0;
              r_cnt         <= 8'd0;
              r_fetch_valid <= 1'b1;
            end else if (r_cnt == LP_LAST) begin
              r_state     <= S_IDLE;
              r_mem_req   <= 1'b0;
              r_cnt       <= 8'd0;
              r_fetch_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MemReq     = r_mem_req;
  assign MemAddr    = r_mem_addr;
  assign PC         = r_pc;
  assign INS        = r_ir;
  assign FetchValid = r_fetch_valid;
  assign FetchErr   = r_fetch_err;
  assign Busy       = (r_state == S_REQ);

endmodule
